// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller for an external combinational-read register file.
// Latency: wr_en follows wr in the same cycle; pointers, count and ovf/udf update on the clock edge.
// Backpressure: push refused when full unless a pop frees a slot in the same cycle; pop refused when empty.
module fifo_ctrl #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wr,
    input  logic         rd,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic         empty,
    output logic         full,
    output logic [W:0]   count,
    output logic         ovf,
    output logic         udf
);

    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

    logic push;
    logic pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH);

    // A full FIFO still takes a push when a simultaneous pop frees the head slot.
    assign push  = wr && (!full || rd) && !clr;
    assign pop   = rd && !empty && !clr;
    assign wr_en = push;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            w_addr <= '0;
            r_addr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (push) begin
                w_addr <= w_addr + W'(1);
            end
            if (pop) begin
                r_addr <= r_addr + W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (W+1)'(1);
                2'b01:   count <= count - (W+1)'(1);
                default: count <= count;
            endcase
            ovf <= wr && full && !rd;
            udf <= rd && empty;
        end
    end

endmodule
